divider_n: RTL and testbench
============================

DIVIDER_N -- requirements
Module: divider_n

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, operand/result width (legal 8..64, even).
REQ-002 SHALL provide parameter: EARLY_OUT, 1, enables the |dividend| < |divisor| fast path when 1.
REQ-003 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: START_DIV  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: CMD_RD  input  2  op: 00 REMU, 01 DIV, 10 DIVU, 11 REM.
REQ-007 SHALL have port: OP1_SE  input  WIDTH  dividend.
REQ-008 SHALL have port: OP2_SE  input  WIDTH  divisor.
REQ-009 SHALL have port: KILL_DIV  input  1  abort of the in-flight operation (pipeline flush).
REQ-010 SHALL have port: BUSY_DIV  output  1  high while an accepted operation is in flight.
REQ-011 SHALL have port: DONE_DIV  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: RES_DIV  output  WIDTH  result.

Function
REQ-013 Cycle numbering: START cycle = cycle 0; a START is accepted only when the state is IDLE, KILL_DIV is low and reset is low; CMD_RD, OP1_SE and OP2_SE are registered at acceptance.
REQ-014 States: IDLE, SETUP, RUN, DONE; any unused encoding SHALL go to IDLE on the next edge.
REQ-015 Normal path: IDLE -> SETUP (cycle 1) -> RUN (cycles 2..WIDTH+1) -> DONE (cycle WIDTH+2) -> IDLE.
REQ-016 Fast path: divisor zero, operands bit-identical, signed overflow, or (EARLY_OUT=1 and |dividend| < |divisor|) SHALL go IDLE -> DONE, with DONE in cycle 1.
REQ-017 Fast-path precedence: zero > overflow > identical > early-out.
REQ-018 SETUP: signed ops (01, 11) take the two's-complement magnitude of negative operands; record quotient sign = op1[MSB] XOR op2[MSB]; record remainder sign = op1[MSB]; clear quotient; clear step counter.
REQ-019 RUN: one restoring step per cycle on a 2*WIDTH-bit remainder/divisor pair; the quotient bit = (remainder >= shifted divisor), subtracting when set; the counter SHALL be $clog2(WIDTH)+1 bits and exit after exactly WIDTH steps.
REQ-020 DONE: negate the quotient if its sign is set; negate the remainder if its sign is set; select the remainder for 00/11, else the quotient.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder = dividend (unmodified).
REQ-022 Signed overflow (01/11, dividend = 1 followed by WIDTH-1 zeros, divisor all-ones) SHALL give quotient = dividend and remainder 0.
REQ-023 Identical nonzero operands SHALL give quotient 1 and remainder 0.
REQ-024 Early-out SHALL give quotient 0 and remainder = dividend.
REQ-025 DONE_DIV SHALL be high exactly in the DONE cycle; RES_DIV SHALL be valid in that cycle and held until the next acceptance.
REQ-026 BUSY_DIV SHALL be high from cycle 1 through the DONE cycle inclusive, and low in IDLE.
REQ-027 START_DIV while BUSY_DIV is high (including the DONE cycle) SHALL be ignored, with no queueing.
REQ-028 KILL_DIV high in SETUP, RUN or DONE SHALL force IDLE on the next edge; DONE_DIV SHALL then be low in the DONE cycle, and RES_DIV keeps its previous value.
REQ-029 KILL_DIV and START_DIV both high in IDLE: START SHALL be dropped.
REQ-030 Back-to-back: a new START is accepted at the earliest in the cycle after DONE.

Reset
REQ-031 reset high at a rising edge SHALL force IDLE and set BUSY_DIV=0, DONE_DIV=0, RES_DIV=0, and clear the command, sign and counter registers, overriding START_DIV and KILL_DIV.
REQ-032 Reset mid-RUN SHALL abandon the operation with no DONE pulse; a START in the first cycle after reset deasserts SHALL be accepted.

Verification (WIDTH=32 unless stated)
REQ-033 DIV 0xFFFFFFF9 / 0x00000002 -> DONE cycle 34, RES 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF.
REQ-034 DIVU 100/7 -> RES 14 in cycle 34; REMU -> 2; BUSY high cycles 1..34.
REQ-035 DIVU 0x1234/0 -> DONE cycle 1, RES 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> cycle 1, RES 0x80000000; REM on the same operands -> 0.
REQ-037 DIVU 5/9 (EARLY_OUT=1) -> cycle 1, RES 0; KILL in cycle 10 of DIVU 1000/3 -> no DONE, IDLE at cycle 11; a new START at cycle 11 completes normally.
REQ-038 WIDTH=8: DIV 0x81/0x03 -> RES 0xD6 in cycle 10; REM -> 0xFF; START during cycle 5 is ignored.

Source files
------------

// File: rtl/divider_n.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with a single-cycle fast path for divide-by-zero, overflow, identical and small-dividend cases.
module divider_n #(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START_DIV,
    input  logic [1:0]       CMD_RD,
    input  logic [WIDTH-1:0] OP1_SE,
    input  logic [WIDTH-1:0] OP2_SE,
    input  logic             KILL_DIV,
    output logic             BUSY_DIV,
    output logic             DONE_DIV,
    output logic [WIDTH-1:0] RES_DIV
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    state_t             state_q;
    logic [1:0]         cmd_q;
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   op2_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   res_q;
    logic [2*WIDTH-1:0] rem_q;
    logic [2*WIDTH-1:0] dvs_q;
    logic               q_sign_q;
    logic               r_sign_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_signed;
    logic               div_zero;
    logic               ovf;
    logic               ident;
    logic               early;
    logic               fast;
    logic               accept;
    logic [WIDTH-1:0]   fast_quo;
    logic [WIDTH-1:0]   fast_rem;

    // Fast-path detection on the raw request; earlier tests take precedence.
    always_comb begin
        in_signed = CMD_RD[0];
        div_zero  = (OP2_SE == '0);
        ovf       = in_signed && (OP1_SE == MIN_NEG) && (OP2_SE == '1);
        ident     = (OP1_SE == OP2_SE);
        early     = (EARLY_OUT != 0) &&
                    (magnitude(OP1_SE, in_signed) < magnitude(OP2_SE, in_signed));
        fast      = div_zero || ovf || ident || early;
        accept    = (state_q == S_IDLE) && START_DIV && !KILL_DIV;
        fast_quo  = '0;
        fast_rem  = OP1_SE;
        if (div_zero) begin
            fast_quo = '1;
            fast_rem = OP1_SE;
        end else if (ovf) begin
            fast_quo = OP1_SE;
            fast_rem = '0;
        end else if (ident) begin
            fast_quo = ONE;
            fast_rem = '0;
        end
    end

    logic               step_ge;
    logic [2*WIDTH-1:0] step_diff;
    logic               sel_rem;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic [WIDTH-1:0]   result;

    always_comb begin
        step_ge   = (rem_q >= dvs_q);
        step_diff = rem_q - dvs_q;
        quo_fin   = q_sign_q ? negate(quo_q) : quo_q;
        rem_fin   = r_sign_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        sel_rem   = (cmd_q == 2'b00) || (cmd_q == 2'b11);
        result    = sel_rem ? rem_fin : quo_fin;
    end

    // A kill in the DONE cycle suppresses both the pulse and the result update.
    assign BUSY_DIV = (state_q != S_IDLE);
    assign DONE_DIV = (state_q == S_DONE) && !KILL_DIV;
    assign RES_DIV  = DONE_DIV ? result : res_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q <= CMD_RD;
                        op1_q <= OP1_SE;
                        op2_q <= OP2_SE;
                        if (fast) begin
                            quo_q    <= fast_quo;
                            rem_q    <= {{WIDTH{1'b0}}, fast_rem};
                            q_sign_q <= 1'b0;
                            r_sign_q <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (KILL_DIV) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q    <= {{WIDTH{1'b0}}, magnitude(op1_q, cmd_q[0])};
                        dvs_q    <= {1'b0, magnitude(op2_q, cmd_q[0]), {(WIDTH-1){1'b0}}};
                        quo_q    <= '0;
                        q_sign_q <= cmd_q[0] & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
                        r_sign_q <= cmd_q[0] & op1_q[WIDTH-1];
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                    end
                end
                // Divisor starts at |op2| << (WIDTH-1) and walks right one bit per step.
                S_RUN: begin
                    if (KILL_DIV) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (step_ge) begin
                            rem_q <= step_diff;
                        end
                        quo_q <= {quo_q[WIDTH-2:0], step_ge};
                        dvs_q <= {1'b0, dvs_q[2*WIDTH-1:1]};
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!KILL_DIV) begin
                        res_q <= result;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_n.sv
// Randomized scoreboard bench for divider_n at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_divider_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, kill;
    logic [1:0]  cmd;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] res;
    logic        start8, kill8;
    logic [1:0]  cmd8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  res8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    logic [31:0] last32 = '0;
    logic [7:0]  last8  = '0;
    logic        rst_e32, rst_e8;

    divider_n #(.WIDTH(32), .EARLY_OUT(1)) dut32 (
        .clk(clk), .reset(reset), .START_DIV(start), .CMD_RD(cmd), .OP1_SE(op1), .OP2_SE(op2),
        .KILL_DIV(kill), .BUSY_DIV(busy), .DONE_DIV(done), .RES_DIV(res)
    );

    divider_n #(.WIDTH(8), .EARLY_OUT(1)) dut8 (
        .clk(clk), .reset(reset), .START_DIV(start8), .CMD_RD(cmd8), .OP1_SE(a8), .OP2_SE(b8),
        .KILL_DIV(kill8), .BUSY_DIV(busy8), .DONE_DIV(done8), .RES_DIV(res8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truncating division semantics; remainder takes the dividend's sign.
    function automatic logic [63:0] ref_res(int w, logic [1:0] c, logic [63:0] a, logic [63:0] b);
        logic [63:0] m, h;
        longint sa, sb, q, r;
        m = (64'd1 << w) - 64'd1;
        h = 64'd1 << (w - 1);
        if (b == 0) begin
            q = longint'(m);
            r = longint'(a);
        end else if (c[0]) begin
            sa = longint'(a ^ h) - longint'(h);
            sb = longint'(b ^ h) - longint'(h);
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = longint'(a / b);
            r = longint'(a % b);
        end
        return ((c == 2'b00 || c == 2'b11) ? 64'(r) : 64'(q)) & m;
    endfunction

    function automatic int ref_lat(int w, logic [1:0] c, logic [63:0] a, logic [63:0] b);
        logic [63:0] h, m;
        longint sa, sb;
        h = 64'd1 << (w - 1);
        m = (64'd1 << w) - 64'd1;
        if (b == 0 || a == b) return 1;
        if (c[0] && a == h && b == m) return 1;
        if (c[0]) begin
            sa = longint'(a ^ h) - longint'(h);
            sb = longint'(b ^ h) - longint'(h);
            if (sa < 0) sa = -sa;
            if (sb < 0) sb = -sb;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        if (sa < sb) return 1;
        return w + 2;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'($urandom_range(0, 9));
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic goto_cycle(input int t);
        int n = 0;
        while (cyc < t && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic issue32(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                           input bit expect_done, output int sc);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue32_idle", busy, 1'b0);
        cmd = c; op1 = a; op2 = b; start = 1'b1;
        sc = cyc;
        if (expect_done) q32.push_back('{ref_res(32, c, a, b), cyc + ref_lat(32, c, a, b)});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                          input bit expect_done, output int sc);
        int n = 0;
        while (busy8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue8_idle", busy8, 1'b0);
        cmd8 = c; a8 = a; b8 = b; start8 = 1'b1;
        sc = cyc;
        if (expect_done) q8.push_back('{ref_res(8, c, a, b), cyc + ref_lat(8, c, a, b)});
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 64'(q32.size() + q8.size()), 64'd0);
    endtask

    always begin
        @(posedge clk);
        rst_e32 = reset;
        @(negedge clk);
        if (rst_e32) begin
            check("reset32_busy", busy, 1'b0);
            check("reset32_done", done, 1'b0);
            check("reset32_res", res, 32'h0);
            last32 = '0;
        end else if (done) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", done, 1'b0);
            end else begin
                e32 = q32.pop_front();
                check("result32", res, e32.res);
                check("due32", 64'(cyc), 64'(e32.due));
            end
            last32 = res;
        end else begin
            check("hold32", res, last32);
        end
    end

    always begin
        @(posedge clk);
        rst_e8 = reset;
        @(negedge clk);
        if (rst_e8) begin
            check("reset8_busy", busy8, 1'b0);
            check("reset8_res", res8, 8'h0);
            last8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", done8, 1'b0);
            end else begin
                e8 = q8.pop_front();
                check("result8", res8, e8.res);
                check("due8", 64'(cyc), 64'(e8.due));
            end
            last8 = res8;
        end else begin
            check("hold8", res8, last8);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic [1:0]  rc;
        reset = 1'b1; start = 1'b0; kill = 1'b0; cmd = '0; op1 = '0; op2 = '0;
        start8 = 1'b0; kill8 = 1'b0; cmd8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue32(2'b01, 32'hFFFF_FFF9, 32'h2, 1'b1, sc);
        issue32(2'b11, 32'hFFFF_FFF9, 32'h2, 1'b1, sc);
        issue32(2'b00, 32'd100, 32'd7, 1'b1, sc);
        issue32(2'b10, 32'h1234, 32'h0, 1'b1, sc);
        issue32(2'b00, 32'h1234, 32'h0, 1'b1, sc);
        issue32(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, sc);
        issue32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, sc);
        issue32(2'b10, 32'd5, 32'd9, 1'b1, sc);
        issue32(2'b01, 32'hFFFF_FFF3, 32'hFFFF_FFF3, 1'b1, sc);
        drain();

        // BUSY window of a full-length DIVU 100/7.
        issue32(2'b10, 32'd100, 32'd7, 1'b1, sc);
        for (int k = 1; k <= 35; k++) begin
            goto_cycle(sc + k);
            check($sformatf("busy_window_c%0d", k), busy, (k <= 34) ? 1'b1 : 1'b0);
        end
        drain();

        // Kill mid-RUN, then restart in the very next cycle.
        issue32(2'b10, 32'd1000, 32'd3, 1'b0, sc);
        goto_cycle(sc + 10);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_idle_c11", busy, 1'b0);
        issue32(2'b10, 32'd1000, 32'd3, 1'b1, sc);
        drain();

        // Kill landing in the DONE cycle.
        issue32(2'b10, 32'd100, 32'd7, 1'b0, sc);
        goto_cycle(sc + 34);
        kill = 1'b1;
        #1;
        check("kill_done_pulse", done, 1'b0);
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done_idle", busy, 1'b0);

        // START and KILL together in IDLE: dropped.
        cmd = 2'b10; op1 = 32'd9; op2 = 32'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_start_drop", busy, 1'b0);

        // Reset mid-RUN, then accept a START in the first cycle after it.
        issue32(2'b10, 32'd1000, 32'd3, 1'b0, sc);
        goto_cycle(sc + 6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_busy", busy, 1'b0);
        issue32(2'b10, 32'd77, 32'd5, 1'b1, sc);
        drain();

        // WIDTH=8 signed case with an ignored START while busy.
        issue8(2'b01, 8'h81, 8'h03, 1'b1, sc);
        goto_cycle(sc + 5);
        cmd8 = 2'b10; a8 = 8'h10; b8 = 8'h02; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        issue8(2'b11, 8'h81, 8'h03, 1'b1, sc);
        drain();

        for (int i = 0; i < 150; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = pick32();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick32();
            issue32(rc, ra, rb, 1'b1, sc);
        end
        for (int i = 0; i < 120; i++) begin
            rc  = 2'($urandom_range(0, 3));
            ra8 = pick8();
            rb8 = ($urandom_range(0, 7) == 0) ? ra8 : pick8();
            issue8(rc, ra8, rb8, 1'b1, sc);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
